// File: rtl/fp_matrix_scanner.sv
// Front-panel 8x8 key matrix scanner: row sequencing, 2-flop sense sync, per-key
// debounce and a press/release event FIFO. Define FP_AUTOREPEAT_EN for key auto-repeat.

module fp_key_cell #(
    parameter int DEBOUNCE_SCANS = 4,
    parameter int CW             = 3
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    input  logic smp,
    output logic key,
    output logic fire
);
    logic [CW-1:0] cnt;
    logic          hit;

    assign hit  = (cnt + 1'b1) == CW'(DEBOUNCE_SCANS);
    assign fire = en && (smp != key) && hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
            key <= 1'b0;
        end else if (en) begin
            if (smp == key) begin
                cnt <= '0;
            end else if (hit) begin
                key <= smp;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module fp_matrix_scanner #(
    parameter int SETTLE_CYCLES  = 250,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int REPEAT_DELAY   = 32,
    parameter int REPEAT_PERIOD  = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        scan_en,
    input  logic [7:0]  sense,
    output logic [7:0]  dir,
    output logic [63:0] keys,
    output logic        scan_done,
    output logic        ev_valid,
    output logic [7:0]  ev_data,
    input  logic        ev_ready,
    output logic        overflow,
    input  logic        clr_ovf
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int CW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, EVAL} state_t;

    typedef struct packed {
        logic       rpt;
        logic       press;
        logic [5:0] code;
    } ev_t;

    // Parameter range guard: an illegal configuration elaborates nothing here.
    if (SETTLE_CYCLES < 1 || DEBOUNCE_SCANS < 1 || FIFO_DEPTH < 2 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    end

    state_t        state;
    logic [7:0]    sense_meta, sense_sync, sync, snap;
    logic [2:0]    row, col;
    logic [SW-1:0] settle_cnt;
    logic [5:0]    kidx;
    logic          eval, smp, ev_push;
    logic [63:0]   fire_vec;
    ev_t           push_word;
    logic          push;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sense_meta <= 8'hFF;
            sense_sync <= 8'hFF;
        end else begin
            sense_meta <= sense;
            sense_sync <= sense_meta;
        end
    end
    assign sync = ~sense_sync;

    // dir stays on the row through SETTLE, CAPTURE and EVAL (SETTLE_CYCLES+9 cycles).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            settle_cnt <= '0;
            dir        <= '0;
            snap       <= '0;
            scan_done  <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            case (state)
                IDLE: begin
                    dir <= '0;
                    if (scan_en) begin
                        state      <= SETTLE;
                        row        <= '0;
                        settle_cnt <= '0;
                        dir        <= 8'h01;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                        state      <= CAPTURE;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    snap  <= sync;
                    col   <= '0;
                    state <= EVAL;
                end
                EVAL: begin
                    col <= col + 1'b1;
                    if (col == 3'd7) begin
                        if (row != 3'd7) begin
                            row   <= row + 1'b1;
                            dir   <= 8'h01 << (row + 3'd1);
                            state <= SETTLE;
                        end else begin
                            scan_done <= 1'b1;
                            row       <= '0;
                            if (scan_en) begin
                                state <= SETTLE;
                                dir   <= 8'h01;
                            end else begin
                                state <= IDLE;
                                dir   <= '0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign eval = (state == EVAL);
    assign kidx = {row, col};
    assign smp  = snap[col];

    for (genvar k = 0; k < 64; k++) begin : g_key
        fp_key_cell #(
            .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
            .CW             (CW)
        ) u_cell (
            .clk    (clk),
            .resetn (resetn),
            .en     (eval && (kidx == 6'(k))),
            .smp    (smp),
            .key    (keys[k]),
            .fire   (fire_vec[k])
        );
    end

    // Columns are serialised, so at most one cell fires per cycle.
    assign ev_push = |fire_vec;

`ifdef FP_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [5:0]    rep_code;
    logic          rep_active, rep_first, rep_hit, rep_push;
    logic [RW-1:0] rep_cnt, rep_target;

    assign rep_target = rep_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD);
    assign rep_hit    = (rep_cnt + 1'b1) == rep_target;
    // A repeat colliding with a real event is skipped silently.
    assign rep_push   = scan_done && rep_active && keys[rep_code] && rep_hit && !ev_push;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rep_code   <= '0;
            rep_active <= 1'b0;
            rep_first  <= 1'b1;
            rep_cnt    <= '0;
        end else if (ev_push && smp) begin
            rep_code   <= kidx;
            rep_active <= 1'b1;
            rep_first  <= 1'b1;
            rep_cnt    <= '0;
        end else if (ev_push && !smp && (kidx == rep_code)) begin
            rep_active <= 1'b0;
        end else if (scan_done && rep_active) begin
            if (rep_hit) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end

    assign push      = ev_push || rep_push;
    assign push_word = ev_push ? ev_t'{1'b0, smp, kidx} : ev_t'{1'b1, 1'b1, rep_code};
`else
    assign push      = ev_push;
    assign push_word = ev_t'{1'b0, smp, kidx};
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0] count;
    logic          full, pop, wr, drop;

    assign full     = (count == NW'(FIFO_DEPTH));
    assign ev_valid = (count != '0);
    assign pop      = ev_valid && ev_ready;
    assign wr       = push && (!full || pop);
    assign drop     = push && full && !pop;
    assign ev_data  = ev_valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + NW'(wr) - NW'(pop);
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fp_matrix_scanner.sv
// Bench for fp_matrix_scanner: switch-matrix model driving sense from dir, event scoreboard.
module tb_fp_matrix_scanner;
    localparam int S    = 10;
    localparam int P    = S + 9;
    localparam int SCAN = 8 * P;
    localparam logic [63:0] MASK5 = (64'd1 << 3) | (64'd1 << 10) | (64'd1 << 20) |
                                    (64'd1 << 40) | (64'd1 << 50);

    logic        clk = 1'b0, resetn = 1'b0, scan_en = 1'b0, ev_ready = 1'b0, clr_ovf = 1'b0;
    logic [7:0]  sense, dir, ev_data;
    logic [63:0] keys;
    logic        scan_done, ev_valid, overflow;
    logic [63:0] pressed = '0;
    int          total = 0, bad = 0;
    logic [7:0]  sb [$];

    always #5 clk = ~clk;

    fp_matrix_scanner #(
        .SETTLE_CYCLES (S),
        .DEBOUNCE_SCANS(4),
        .FIFO_DEPTH    (4),
        .REPEAT_DELAY  (32),
        .REPEAT_PERIOD (8)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .scan_en  (scan_en),
        .sense    (sense),
        .dir      (dir),
        .keys     (keys),
        .scan_done(scan_done),
        .ev_valid (ev_valid),
        .ev_data  (ev_data),
        .ev_ready (ev_ready),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    // Key matrix: a closed key pulls its column low while its row is driven.
    always_comb begin
        sense = 8'hFF;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (dir[r] && pressed[r*8+c]) sense[c] = 1'b0;
    end

    always @(negedge clk) begin : mon
        logic [7:0] e;
        if (resetn && ev_valid && ev_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL event_unexpected got=%02h want=none", ev_data);
            end else begin
                e = sb.pop_front();
                if (ev_data !== e) begin
                    bad++;
                    $display("FAIL event_data got=%02h want=%02h", ev_data, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic wait_scan_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (scan_done !== 1'b1 && n < 2 * SCAN);
        if (scan_done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL scan_done_timeout got=%0d cycles want<%0d", n, 2 * SCAN);
        end
    endtask

    task automatic test_reset();
        #2;
        total++; if (dir !== 8'h00)      begin bad++; $display("FAIL rst_dir got=%h want=00", dir); end
        total++; if (keys !== 64'h0)     begin bad++; $display("FAIL rst_keys got=%h want=0", keys); end
        total++; if (scan_done !== 1'b0) begin bad++; $display("FAIL rst_scan_done got=%b want=0", scan_done); end
        total++; if (ev_valid !== 1'b0)  begin bad++; $display("FAIL rst_ev_valid got=%b want=0", ev_valid); end
        total++; if (ev_data !== 8'h00)  begin bad++; $display("FAIL rst_ev_data got=%h want=00", ev_data); end
        total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL rst_overflow got=%b want=0", overflow); end
        @(posedge clk); #1 resetn = 1'b1;
        repeat (5) @(negedge clk);
        total++; if (dir !== 8'h00) begin bad++; $display("FAIL idle_dir got=%h want=00", dir); end
    endtask

    task automatic test_idle_scan();
        logic [7:0] exp;
        @(posedge clk); #1 scan_en = 1'b1;
        wait_scan_done();
        for (int r = 0; r < 8; r++) begin
            exp = 8'h01 << r;
            total++; if (dir !== exp) begin bad++; $display("FAIL row_dir_start got=%h want=%h", dir, exp); end
            repeat (P - 1) @(negedge clk);
            total++; if (dir !== exp) begin bad++; $display("FAIL row_dir_end got=%h want=%h", dir, exp); end
            total++; if (scan_done !== 1'b0) begin bad++; $display("FAIL early_scan_done got=%b want=0", scan_done); end
            @(negedge clk);
        end
        total++; if (scan_done !== 1'b1) begin bad++; $display("FAIL scan_period got=%b want=1", scan_done); end
        total++; if (keys !== 64'h0)     begin bad++; $display("FAIL idle_keys got=%h want=0", keys); end
        total++; if (ev_valid !== 1'b0)  begin bad++; $display("FAIL idle_ev_valid got=%b want=0", ev_valid); end
    endtask

    task automatic test_press_release();
        ev_ready = 1'b1;
        for (int ph = 0; ph < 2; ph++) begin
            wait_scan_done();
            pressed[19] = (ph == 0);
            sb.push_back((ph == 0) ? 8'h53 : 8'h13);
            repeat (3) wait_scan_done();
            total++; if (keys[19] !== (ph != 0)) begin bad++; $display("FAIL key19_scan3 got=%b want=%b", keys[19], ph != 0); end
            wait_scan_done();
            total++; if (keys[19] !== (ph == 0)) begin bad++; $display("FAIL key19_scan4 got=%b want=%b", keys[19], ph == 0); end
            total++; if (sb.size() != 0) begin bad++; $display("FAIL key19_event_pending got=%0d want=0", sb.size()); end
        end
    endtask

    task automatic test_bounce();
        ev_ready = 1'b0;
        wait_scan_done();
        pressed[19] = 1'b1; repeat (3) wait_scan_done();
        pressed[19] = 1'b0; wait_scan_done();
        total++; if (keys[19] !== 1'b0) begin bad++; $display("FAIL bounce_mid_key got=%b want=0", keys[19]); end
        pressed[19] = 1'b1; repeat (3) wait_scan_done();
        pressed[19] = 1'b0; wait_scan_done();
        total++; if (keys[19] !== 1'b0) begin bad++; $display("FAIL bounce_key got=%b want=0", keys[19]); end
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL bounce_ev_valid got=%b want=0", ev_valid); end
    endtask

    task automatic release_group();
        ev_ready = 1'b1;
        wait_scan_done();
        pressed = '0;
        sb.push_back(8'h03); sb.push_back(8'h0A); sb.push_back(8'h14);
        sb.push_back(8'h28); sb.push_back(8'h32);
        repeat (4) wait_scan_done();
        total++; if (sb.size() != 0)    begin bad++; $display("FAIL release_pending got=%0d want=0", sb.size()); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL release_overflow got=%b want=0", overflow); end
        total++; if (keys !== 64'h0)    begin bad++; $display("FAIL release_keys got=%h want=0", keys); end
    endtask

    task automatic test_overflow();
        ev_ready = 1'b0;
        wait_scan_done();
        pressed = MASK5;
        sb.push_back(8'h43); sb.push_back(8'h4A); sb.push_back(8'h54); sb.push_back(8'h68);
        repeat (4) wait_scan_done();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", overflow); end
        total++; if (ev_valid !== 1'b1) begin bad++; $display("FAIL ovf_ev_valid got=%b want=1", ev_valid); end
        total++; if (ev_data !== 8'h43) begin bad++; $display("FAIL ovf_head got=%h want=43", ev_data); end
        total++; if (keys !== MASK5)    begin bad++; $display("FAIL ovf_keys got=%h want=%h", keys, MASK5); end
        @(posedge clk); #1 clr_ovf = 1'b1;
        @(posedge clk); #1 clr_ovf = 1'b0;
        @(negedge clk);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
        ev_ready = 1'b1;
        repeat (8) @(negedge clk);
        total++; if (sb.size() != 0)    begin bad++; $display("FAIL ovf_drain got=%0d want=0", sb.size()); end
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b want=0", ev_valid); end
        release_group();
    endtask

    task automatic test_full_pop();
        ev_ready = 1'b0;
        wait_scan_done();
        pressed = MASK5;
        sb.push_back(8'h43); sb.push_back(8'h4A); sb.push_back(8'h54);
        sb.push_back(8'h68); sb.push_back(8'h72);
        repeat (3) wait_scan_done();
        // key 50 = row 6 col 2 evaluates this many cycles after the scan_done cycle
        repeat (6 * P + S + 1 + 2) @(posedge clk);
        #1 ev_ready = 1'b1;
        @(posedge clk);
        #1 ev_ready = 1'b0;
        wait_scan_done();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_pop_overflow got=%b want=0", overflow); end
        total++; if (sb.size() != 4)    begin bad++; $display("FAIL full_pop_depth got=%0d want=4", sb.size()); end
        total++; if (ev_data !== 8'h4A) begin bad++; $display("FAIL full_pop_head got=%h want=4a", ev_data); end
        ev_ready = 1'b1;
        repeat (8) @(negedge clk);
        total++; if (sb.size() != 0)    begin bad++; $display("FAIL full_pop_drain got=%0d want=0", sb.size()); end
        release_group();
    endtask

    task automatic test_scan_stop();
        wait_scan_done();
        repeat (3 * P) @(negedge clk);
        scan_en = 1'b0;
        wait_scan_done();
        total++; if (dir !== 8'h00) begin bad++; $display("FAIL stop_dir got=%h want=00", dir); end
        repeat (2 * P) @(negedge clk);
        total++; if (dir !== 8'h00) begin bad++; $display("FAIL stop_idle_dir got=%h want=00", dir); end
        scan_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        ev_ready = 1'b1;
        wait_scan_done();
        pressed[19] = 1'b1;
        sb.push_back(8'h53);
        repeat (4) wait_scan_done();
        total++; if (keys[19] !== 1'b1) begin bad++; $display("FAIL rmid_key_pre got=%b want=1", keys[19]); end
        repeat (5 * P + 3) @(negedge clk);
        total++; if (dir !== 8'h20) begin bad++; $display("FAIL rmid_dir_pre got=%h want=20", dir); end
        #1 resetn = 1'b0;
        #1;
        total++; if (dir !== 8'h00)  begin bad++; $display("FAIL rmid_dir got=%h want=00", dir); end
        total++; if (keys !== 64'h0) begin bad++; $display("FAIL rmid_keys got=%h want=0", keys); end
        pressed = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        total++; if (dir !== 8'h00) begin bad++; $display("FAIL rmid_idle got=%h want=00", dir); end
        @(negedge clk);
        total++; if (dir !== 8'h01) begin bad++; $display("FAIL rmid_restart_row got=%h want=01", dir); end
        while (scan_done !== 1'b1 && n < 2 * SCAN) begin
            @(negedge clk);
            n++;
        end
        total++; if (n != SCAN) begin bad++; $display("FAIL rmid_scan_len got=%0d want=%0d", n, SCAN); end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_press_release();
        test_bounce();
        test_overflow();
        test_full_pop();
        test_scan_stop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
